// File: rtl/pam_threshold_demod_axis_if.sv
// Bundles the two streaming interfaces of the PAM demodulator:
//  - sample stream from the frame synchroniser (syn_demod_*)
//  - AXI-Stream word output toward the host FIFO (m_axi_*)
// The "slave" modport is the demodulator's view. It consumes samples and
// produces words. The "master" modport is the surrounding environment.
interface pam_threshold_demod_axis_if #(
  parameter int DATA_W = 12,
  parameter int AXI_W  = 32
);
  logic                 syn_demod_valid;
  logic [DATA_W-1:0]    syn_demod_data;
  logic                 syn_demod_ready;
  logic                 m_axi_tready;
  logic                 m_axi_tvalid;
  logic [AXI_W-1:0]     m_axi_tdata;
  logic [AXI_W/8-1:0]   m_axi_tkeep;
  logic                 m_axi_tlast;

  modport slave (
    input  syn_demod_valid, syn_demod_data, m_axi_tready,
    output syn_demod_ready, m_axi_tvalid, m_axi_tdata, m_axi_tkeep, m_axi_tlast
  );

  modport master (
    output syn_demod_valid, syn_demod_data, m_axi_tready,
    input  syn_demod_ready, m_axi_tvalid, m_axi_tdata, m_axi_tkeep, m_axi_tlast
  );
endinterface

// File: rtl/pam_threshold_demod_axis.sv
// PAM hard-decision demodulator.
// Each frame opens with an ascending pilot ramp of L = 2^PAM_BITS levels.
// Midpoints between adjacent pilots become the L-1 decision thresholds.
// The following FRAME_SYMS samples are sliced against those thresholds.
// Symbols are packed MSB-first into AXI_W-bit words, and each word is
// presented through a single output register with valid/ready flow control.
module pam_threshold_demod_axis #(
  parameter int DATA_W     = 12,
  parameter int PAM_BITS   = 4,
  parameter int FRAME_SYMS = 1024,
  parameter int AXI_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pam_threshold_demod_axis_if.slave    bus,
  output logic                         frame_done,
  output logic [15:0]                  frame_cnt
);

  localparam int L      = 1 << PAM_BITS;
  localparam int NTHR   = L - 1;
  localparam int SPW    = AXI_W / PAM_BITS;
  localparam int SLOT_W = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int SYM_W  = (FRAME_SYMS > 1) ? $clog2(FRAME_SYMS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PILOT = 2'd1,
    DATA  = 2'd2
  } state_e;

  state_e                     state_q, state_d;

  logic signed [DATA_W-1:0]   prev_q, prev_d;
  logic signed [DATA_W-1:0]   thr_q [NTHR];
  logic signed [DATA_W-1:0]   thr_d [NTHR];
  logic [PAM_BITS-1:0]        pil_cnt_q, pil_cnt_d;
  logic [SYM_W-1:0]           sym_cnt_q, sym_cnt_d;
  logic [SLOT_W-1:0]          slot_q, slot_d;
  logic [AXI_W-1:0]           pack_q, pack_d;
  logic [AXI_W-1:0]           tdata_q, tdata_d;
  logic                       tvalid_q, tvalid_d;
  logic                       tlast_q, tlast_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;

  logic signed [DATA_W-1:0]   sample;
  logic signed [DATA_W:0]     pair_sum;
  logic signed [DATA_W-1:0]   pair_avg;
  logic [PAM_BITS-1:0]        symbol;
  logic [AXI_W-1:0]           next_word;
  logic                       syn_ready;
  logic                       accept;
  logic                       handshake;
  logic                       pilot_last;
  logic                       word_done;
  logic                       frame_end;

  assign sample = bus.syn_demod_data;

  // Handshake and position decodes shared by the FSM and the datapath.
  always_comb begin
    pilot_last = &pil_cnt_q;
    word_done  = (slot_q == SLOT_W'(SPW - 1));
    frame_end  = (sym_cnt_q == SYM_W'(FRAME_SYMS - 1));
    handshake  = tvalid_q && bus.m_axi_tready;
    // Only the symbol that would complete a word can be blocked. It needs the
    // output register, and that register is still holding an unaccepted word.
    syn_ready  = !((state_q == DATA) && word_done && tvalid_q && !bus.m_axi_tready);
    accept     = bus.syn_demod_valid && syn_ready;
  end

  // Threshold midpoint is formed one bit wider so the sum cannot overflow,
  // then arithmetically halved and truncated back to the sample width.
  always_comb begin
    pair_sum = {prev_q[DATA_W-1], prev_q} + {sample[DATA_W-1], sample};
    pair_avg = pair_sum[DATA_W:1];
  end

  // Symbol decision: count of thresholds strictly exceeded by the sample.
  always_comb begin
    symbol = '0;
    for (int k = 0; k < NTHR; k++) begin
      if (sample > thr_q[k]) symbol = symbol + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: frame walks IDLE -> PILOT -> DATA -> IDLE on accepts only.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)               state_d = PILOT;
      PILOT:   if (accept && pilot_last) state_d = DATA;
      DATA:    if (accept && frame_end)  state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Datapath and output next-values: threshold capture, slicing, packing, output register.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    prev_d      = prev_q;
    thr_d       = thr_q;
    pil_cnt_d   = pil_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    slot_d      = slot_q;
    pack_d      = pack_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    tvalid_d    = tvalid_q;
    next_word   = pack_q;

    // A consumed word frees the register. A word loaded below in the same
    // cycle sets valid again, so back-to-back words see no bubble.
    if (handshake) tvalid_d = 1'b0;

    for (int n = 0; n < SPW; n++) begin
      if (slot_q == SLOT_W'(n)) next_word[AXI_W-1-n*PAM_BITS -: PAM_BITS] = symbol;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          prev_d    = sample;
          pil_cnt_d = PAM_BITS'(1);
        end
      end
      PILOT: begin
        if (accept) begin
          for (int k = 0; k < NTHR; k++) begin
            if (k == int'(pil_cnt_q) - 1) thr_d[k] = pair_avg;
          end
          prev_d    = sample;
          pil_cnt_d = pil_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (accept) begin
          sym_cnt_d = frame_end ? '0 : sym_cnt_q + 1'b1;
          if (word_done) begin
            slot_d   = '0;
            pack_d   = '0;
            tdata_d  = next_word;
            tlast_d  = frame_end;
            tvalid_d = 1'b1;
          end else begin
            slot_d = slot_q + 1'b1;
            pack_d = next_word;
          end
        end
      end
      default: ;
    endcase

    frame_cnt_d = frame_cnt_q + {15'd0, handshake && tlast_q};
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= '0;
      // NOTE: the threshold file is only L-1 words of flops, not a RAM. Its
      // reset to 0 is intended, so a frame aborted mid-pilot never slices
      // against stale values.
      for (int k = 0; k < NTHR; k++) thr_q[k] <= '0;
      pil_cnt_q   <= '0;
      sym_cnt_q   <= '0;
      slot_q      <= '0;
      pack_q      <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      prev_q      <= prev_d;
      thr_q       <= thr_d;
      pil_cnt_q   <= pil_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      slot_q      <= slot_d;
      pack_q      <= pack_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Output drive.
  always_comb begin
    bus.syn_demod_ready = syn_ready;
    bus.m_axi_tvalid    = tvalid_q;
    bus.m_axi_tdata     = tdata_q;
    bus.m_axi_tkeep     = '1;
    bus.m_axi_tlast     = tlast_q;
    frame_done          = handshake && tlast_q;
    frame_cnt           = frame_cnt_q;
  end

endmodule

// File: tb/tb_pam_threshold_demod_axis.sv
// Self-checking bench for pam_threshold_demod_axis.
// Two instances share clk/rst_n: a PAM_BITS=4 and a PAM_BITS=2 build.
// A frame-level reference model computes thresholds, symbols and packed words
// arithmetically from the pilots and samples. A negedge monitor scores the
// output stream against those expectations.
module tb_pam_threshold_demod_axis;

  localparam int FRAME = 1024;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pam_threshold_demod_axis_if #(.DATA_W(12), .AXI_W(32)) if4 ();
  pam_threshold_demod_axis_if #(.DATA_W(12), .AXI_W(32)) if2 ();

  logic        done4, done2;
  logic [15:0] cnt4, cnt2;

  pam_threshold_demod_axis #(.DATA_W(12), .PAM_BITS(4), .FRAME_SYMS(FRAME), .AXI_W(32)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (if4),
    .frame_done (done4),
    .frame_cnt  (cnt4)
  );

  pam_threshold_demod_axis #(.DATA_W(12), .PAM_BITS(2), .FRAME_SYMS(FRAME), .AXI_W(32)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (if2),
    .frame_done (done2),
    .frame_cnt  (cnt2)
  );

  // Stimulus drivers and the selected instance's observed signals.
  bit          sel;
  logic        drv_valid;
  logic [11:0] drv_data;
  logic        tready;
  bit          force_low;
  bit          rand_ready;

  assign if4.syn_demod_valid = drv_valid && !sel;
  assign if2.syn_demod_valid = drv_valid && sel;
  assign if4.syn_demod_data  = drv_data;
  assign if2.syn_demod_data  = drv_data;
  assign if4.m_axi_tready    = tready;
  assign if2.m_axi_tready    = tready;

  logic        mon_sready, mon_tvalid, mon_tlast, mon_done;
  logic [31:0] mon_tdata;
  logic [3:0]  mon_tkeep;
  logic [15:0] mon_cnt;

  assign mon_sready = sel ? if2.syn_demod_ready : if4.syn_demod_ready;
  assign mon_tvalid = sel ? if2.m_axi_tvalid    : if4.m_axi_tvalid;
  assign mon_tdata  = sel ? if2.m_axi_tdata     : if4.m_axi_tdata;
  assign mon_tkeep  = sel ? if2.m_axi_tkeep     : if4.m_axi_tkeep;
  assign mon_tlast  = sel ? if2.m_axi_tlast     : if4.m_axi_tlast;
  assign mon_done   = sel ? done2               : done4;
  assign mon_cnt    = sel ? cnt2                : cnt4;

  int checks;
  int errors;

  logic [31:0] exp_data [$];
  bit          exp_last [$];
  logic [31:0] rx_data  [$];
  bit          rx_last  [$];
  int          done_pulses;
  bit          stall_seen;

  int pil [16];
  int dat [FRAME];

  // Downstream ready: always high, random, or forced low.
  always @(posedge clk) begin
    #1;
    if (force_low)       tready = 1'b0;
    else if (rand_ready) tready = 1'($urandom_range(0, 1));
    else                 tready = 1'b1;
  end

  // Output monitor: scoreboard, hold-while-stalled, frame_done coincidence.
  logic [31:0] prev_data;
  logic        prev_last;
  bit          prev_stall;
  logic [31:0] ed;
  bit          el;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (mon_tvalid && tready) begin
        checks++;
        if (exp_data.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected: got data=%h last=%b, no word was expected", mon_tdata, mon_tlast);
        end else begin
          ed = exp_data.pop_front();
          el = exp_last.pop_front();
          if (mon_tdata !== ed || mon_tlast !== el) begin
            errors++;
            $display("FAIL word: got data=%h last=%b, expected data=%h last=%b", mon_tdata, mon_tlast, ed, el);
          end
        end
        rx_data.push_back(mon_tdata);
        rx_last.push_back(mon_tlast);
      end
      if (prev_stall) begin
        checks++;
        if (mon_tvalid !== 1'b1 || mon_tdata !== prev_data || mon_tlast !== prev_last) begin
          errors++;
          $display("FAIL hold: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                   mon_tvalid, mon_tdata, mon_tlast, prev_data, prev_last);
        end
      end
      checks++;
      if (mon_done !== (mon_tvalid && tready && mon_tlast)) begin
        errors++;
        $display("FAIL frame_done: got %b, expected %b", mon_done, mon_tvalid && tready && mon_tlast);
      end
      if (mon_done === 1'b1) done_pulses++;
      prev_stall = mon_tvalid && !tready;
      prev_data  = mon_tdata;
      prev_last  = mon_tlast;
    end
  end

  // Offer one sample and wait for its accept, checking the ready rule each cycle.
  task automatic send(input logic [11:0] d, input int gap, input bit is_data, input int pos, input int spw);
    int  g;
    int  budget;
    bit  ok;
    bit  exp_rdy;
    g = (gap > 0) ? $urandom_range(0, gap) : 0;
    drv_valid = 1'b0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    drv_valid = 1'b1;
    drv_data  = d;
    ok        = 1'b0;
    budget    = 2000;
    while (!ok && budget > 0) begin
      @(negedge clk);
      exp_rdy = !(is_data && pos == spw - 1 && mon_tvalid && !tready);
      checks++;
      if (mon_sready !== exp_rdy) begin
        errors++;
        $display("FAIL syn_demod_ready: got %b, expected %b (data=%b pos=%0d)", mon_sready, exp_rdy, is_data, pos);
      end
      if (mon_sready === 1'b0) stall_seen = 1'b1;
      ok = (mon_sready === 1'b1);
      @(posedge clk);
      #1;
      budget--;
    end
    drv_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept in 2000 cycles, expected an accept");
    end
  endtask

  // Reference model for one frame: pilots -> thresholds -> symbols -> words.
  task automatic run_frame(input int pb, input int p [16], input int x [FRAME], input int gap, input int abort_at);
    int          lv;
    int          spw;
    int          thr [15];
    int          sym;
    logic [31:0] word;
    lv   = 1 << pb;
    spw  = 32 / pb;
    for (int k = 0; k < lv - 1; k++) thr[k] = (p[k] + p[k + 1]) >>> 1;
    for (int k = 0; k < lv; k++) send(12'(p[k]), gap, 1'b0, 0, spw);
    word = '0;
    for (int i = 0; i < FRAME; i++) begin
      if (i == abort_at) return;
      sym = 0;
      for (int k = 0; k < lv - 1; k++) if (x[i] > thr[k]) sym++;
      send(12'(x[i]), gap, 1'b1, i % spw, spw);
      word = word | (32'(sym) << (32 - (i % spw + 1) * pb));
      if (i % spw == spw - 1) begin
        exp_data.push_back(word);
        exp_last.push_back(i == FRAME - 1);
        word = '0;
      end
    end
  endtask

  task automatic drain();
    int budget;
    budget = 20000;
    while (exp_data.size() > 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_data.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d words still outstanding, expected 0", exp_data.size());
    end
  endtask

  task automatic clear_logs();
    rx_data.delete();
    rx_last.delete();
    done_pulses = 0;
    stall_seen  = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_data.delete();
    exp_last.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic ramp_pilots();
    for (int k = 0; k < 16; k++) pil[k] = 256 * k - 1920;
  endtask

  task automatic check_cnt(input string name, input int expv);
    checks++;
    if (mon_cnt !== 16'(expv)) begin
      errors++;
      $display("FAIL %s frame_cnt: got %0d, expected %0d", name, mon_cnt, expv);
    end
  endtask

  task automatic check_words(input string name, input int expv, input int pulses);
    checks++;
    if (rx_data.size() != expv || done_pulses != pulses) begin
      errors++;
      $display("FAIL %s count: got %0d words %0d done pulses, expected %0d words %0d pulses",
               name, rx_data.size(), done_pulses, expv, pulses);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (mon_tvalid !== 1'b0 || mon_tlast !== 1'b0 || mon_tdata !== 32'h0 || mon_done !== 1'b0 ||
        mon_cnt !== 16'h0 || mon_sready !== 1'b1 || mon_tkeep !== 4'hF) begin
      errors++;
      $display("FAIL reset: got valid=%b last=%b data=%h done=%b cnt=%0d ready=%b keep=%h, expected 0 0 0 0 0 1 f",
               mon_tvalid, mon_tlast, mon_tdata, mon_done, mon_cnt, mon_sready, mon_tkeep);
    end
    apply_reset();
  endtask

  // Ramp data at pilot levels: symbols 0..15 repeating, words alternate.
  task automatic test_ramp();
    clear_logs();
    ramp_pilots();
    for (int i = 0; i < FRAME; i++) dat[i] = pil[i % 16];
    run_frame(4, pil, dat, 0, -1);
    drain();
    check_words("ramp", 128, 1);
    for (int w = 0; w < rx_data.size(); w++) begin
      checks++;
      if (rx_data[w] !== ((w % 2 == 0) ? 32'h01234567 : 32'h89ABCDEF) || rx_last[w] !== (w == 127)) begin
        errors++;
        $display("FAIL ramp_word%0d: got %h last=%b, expected %h last=%b", w, rx_data[w], rx_last[w],
                 (w % 2 == 0) ? 32'h01234567 : 32'h89ABCDEF, w == 127);
      end
    end
    check_cnt("ramp", 1);
  endtask

  // Threshold edges: equal-to-threshold falls low, extremes saturate at 0 and 15.
  task automatic test_slicing();
    clear_logs();
    ramp_pilots();
    for (int i = 0; i < FRAME; i++) dat[i] = int'($urandom_range(0, 4095)) - 2048;
    dat[0] = -2048; dat[1] = -1792; dat[2] = -1791; dat[3] = 1792;
    dat[4] = 1793;  dat[5] = 2047;  dat[6] = -2048; dat[7] = 2047;
    run_frame(4, pil, dat, 1, -1);
    drain();
    checks++;
    if (rx_data.size() == 0 || rx_data[0] !== 32'h001EFF0F) begin
      errors++;
      $display("FAIL slicing_edges: got %h, expected 001eff0f", (rx_data.size() > 0) ? rx_data[0] : 32'hx);
    end
    check_cnt("slicing", 2);
  endtask

  // Downstream stalls for 20 cycles mid-frame with the source never idle.
  task automatic test_stall();
    clear_logs();
    ramp_pilots();
    for (int i = 0; i < FRAME; i++) dat[i] = pil[$urandom_range(0, 15)];
    fork
      run_frame(4, pil, dat, 0, -1);
      begin
        repeat (400) @(posedge clk);
        force_low = 1'b1;
        repeat (20) @(posedge clk);
        force_low = 1'b0;
      end
    join
    drain();
    check_words("stall", 128, 1);
    checks++;
    if (!stall_seen) begin
      errors++;
      $display("FAIL stall_ready_drop: got ready never low, expected a drop during the stall");
    end
    check_cnt("stall", 3);
  endtask

  // PAM_BITS=2 build: four levels, repeating 0,1,2,3 symbol pattern.
  task automatic test_pam2();
    clear_logs();
    sel = 1'b1;
    pil[0] = -1536; pil[1] = -512; pil[2] = 512; pil[3] = 1536;
    for (int i = 0; i < FRAME; i++) dat[i] = pil[i % 4];
    run_frame(2, pil, dat, 0, -1);
    drain();
    check_words("pam2", 64, 1);
    for (int w = 0; w < rx_data.size(); w++) begin
      checks++;
      if (rx_data[w] !== 32'h1B1B1B1B) begin
        errors++;
        $display("FAIL pam2_word%0d: got %h, expected 1b1b1b1b", w, rx_data[w]);
      end
    end
    check_cnt("pam2", 1);
    sel = 1'b0;
  endtask

  // Reset after 300 data symbols, then a clean frame.
  task automatic test_reset_mid();
    clear_logs();
    rand_ready = 1'b1;
    ramp_pilots();
    for (int i = 0; i < FRAME; i++) dat[i] = int'($urandom_range(0, 4095)) - 2048;
    run_frame(4, pil, dat, 0, 300);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mon_tvalid !== 1'b0 || mon_tlast !== 1'b0 || mon_tdata !== 32'h0 || mon_done !== 1'b0 || mon_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b last=%b data=%h done=%b cnt=%0d, expected all 0",
               mon_tvalid, mon_tlast, mon_tdata, mon_done, mon_cnt);
    end
    exp_data.delete();
    exp_last.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    for (int i = 0; i < FRAME; i++) dat[i] = int'($urandom_range(0, 4095)) - 2048;
    run_frame(4, pil, dat, 0, -1);
    drain();
    check_words("reset_mid", 128, 1);
    check_cnt("reset_mid", 1);
  endtask

  // Two frames with no drain between, random gaps and random downstream ready.
  task automatic test_back_to_back();
    apply_reset();
    clear_logs();
    rand_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 16; k++) pil[k] = 256 * k - 1920 + int'($urandom_range(0, 200)) - 100;
      for (int i = 0; i < FRAME; i++) dat[i] = int'($urandom_range(0, 4095)) - 2048;
      run_frame(4, pil, dat, 3, -1);
    end
    drain();
    check_words("b2b", 256, 2);
    if (rx_last.size() == 256) begin
      for (int w = 0; w < 256; w++) begin
        checks++;
        if (rx_last[w] !== (w == 127 || w == 255)) begin
          errors++;
          $display("FAIL b2b_tlast%0d: got %b, expected %b", w, rx_last[w], w == 127 || w == 255);
        end
      end
    end
    check_cnt("b2b", 2);
    rand_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by 2 ms, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    sel        = 1'b0;
    drv_valid  = 1'b0;
    drv_data   = '0;
    tready     = 1'b1;
    force_low  = 1'b0;
    rand_ready = 1'b0;
    clear_logs();
    test_reset();
    test_ramp();
    test_slicing();
    test_stall();
    test_pam2();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
